// File: rtl/seg7_stream_checker_pkg.sv
// Shared definitions for the 7-segment display path: encode table, checker states,
// and a table-driven decoder.
package seg7_stream_checker_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index is the hex digit; bit0 = segment a ... bit6 = segment g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    TRACK      = 1'b1
  } state_e;

  // Returns {legal, digit}; anything outside the table, blank included, is illegal.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'b0;
    if (pat != SEG_BLANK) begin
      for (int i = 0; i < 16; i++) begin
        if (pat == SEG_TABLE[i]) res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Two-stage synchronizer followed by a stability counter; emits one accept pulse
// per run of STABLE_CYCLES identical synchronized samples.
module seg7_stable_filter #(
  parameter int W             = 7,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         accept_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [W-1:0]  sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          same;

  assign same = (sync2_q == prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fires on the single transition into STABLE_CYCLES-1; saturation blocks re-firing.
  assign accept_o = ena && same && (cnt_q == CW'(STABLE_CYCLES - 2));
  assign dout_o   = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else if (ena) begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_stream_checker.sv
// Receive-side checker for the 7-segment display path: decode, sequence check, error count.
// Divided-clock period measurement is built only when SEG7_PERIOD_MEAS_EN is defined.
module seg7_stream_checker
  import seg7_stream_checker_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MODULUS       = 10,
  parameter int PERIOD_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [6:0]          seg_in,
  input  logic                div_clk_in,
  output logic [3:0]          value_out,
  output logic                value_valid,
  output logic                illegal_pat,
  output logic                seq_err,
  output logic [7:0]          err_count,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid
);
  logic [6:0] pat;
  logic       accept;
  logic [4:0] dec;
  logic [3:0] expect_val;

  state_e     state_q, state_d;
  logic [3:0] value_q, value_d;
  logic [7:0] err_q, err_d;
  logic       vv_q, vv_d, ill_q, ill_d, seq_q, seq_d;

  seg7_stable_filter #(
    .W             (7),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .din_i    (seg_in),
    .dout_o   (pat),
    .accept_o (accept)
  );

  assign dec        = seg_decode(pat);
  assign expect_val = 4'((32'(value_q) + 32'd1) % MODULUS);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    vv_d    = 1'b0;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    if (accept) begin
      if (!dec[4]) begin
        ill_d = 1'b1;
      end else begin
        // A mismatch still adopts the new value so checking resynchronizes.
        seq_d   = (state_q == TRACK) && (dec[3:0] != expect_val);
        value_d = dec[3:0];
        vv_d    = 1'b1;
        state_d = TRACK;
      end
    end
    err_d = err_q;
    if ((ill_d || seq_d) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_FIRST;
      value_q <= '0;
      err_q   <= '0;
      vv_q    <= 1'b0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      err_q   <= err_d;
      vv_q    <= vv_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
    end
  end

  assign value_out   = value_q;
  assign value_valid = vv_q;
  assign illegal_pat = ill_q;
  assign seq_err     = seq_q;
  assign err_count   = err_q;

`ifdef SEG7_PERIOD_MEAS_EN
  logic                div1_q, div2_q, div3_q, seen_q, rise;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d, period_q, period_d;
  logic                pv_q, pv_d;

  assign rise = div2_q & ~div3_q;

  // per_cnt holds the number of enabled clocks since the last rise, counting the rise cycle.
  always_comb begin
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    pv_d      = 1'b0;
    if (ena) begin
      if (rise) begin
        per_cnt_d = PERIOD_W'(1);
        if (seen_q) begin
          period_d = per_cnt_q;
          pv_d     = 1'b1;
        end
      end else if (per_cnt_q != '1) begin
        per_cnt_d = per_cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div1_q    <= 1'b0;
      div2_q    <= 1'b0;
      div3_q    <= 1'b0;
      seen_q    <= 1'b0;
      per_cnt_q <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
    end else begin
      pv_q <= pv_d;
      if (ena) begin
        div1_q    <= div_clk_in;
        div2_q    <= div1_q;
        div3_q    <= div2_q;
        seen_q    <= seen_q | rise;
        per_cnt_q <= per_cnt_d;
        period_q  <= period_d;
      end
    end
  end

  assign period_out   = period_q;
  assign period_valid = pv_q;
`else
  logic unused_div;
  assign unused_div   = div_clk_in;
  assign period_out   = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_stream_checker.sv
// Self-checking bench for seg7_stream_checker: behavioural model compared every cycle,
// plus directed scenarios with literal expectations and a randomized tail.
module tb_seg7_stream_checker;
  localparam int S   = 4;
  localparam int MOD = 10;
  localparam int PW  = 16;
`ifdef SEG7_PERIOD_MEAS_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          div_clk_in = 1'b0;
  logic [6:0]    seg_in = 7'h00;
  logic [3:0]    value_out;
  logic          value_valid, illegal_pat, seq_err, period_valid;
  logic [7:0]    err_count;
  logic [PW-1:0] period_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  bit started  = 1'b0;
  int n_vv = 0, n_seq = 0, n_ill = 0, n_pv = 0, last_vv_cyc = 0;

  seg7_stream_checker #(
    .STABLE_CYCLES (S),
    .MODULUS       (MOD),
    .PERIOD_W      (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .seg_in       (seg_in),
    .div_clk_in   (div_clk_in),
    .value_out    (value_out),
    .value_valid  (value_valid),
    .illegal_pat  (illegal_pat),
    .seq_err      (seq_err),
    .err_count    (err_count),
    .period_out   (period_out),
    .period_valid (period_valid)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: synced sample = input seen two enabled clocks earlier; a pattern is
  // taken once its run of identical synced samples reaches S (reset leaves three blanks).
  logic [6:0] sp0, sp1, s_last;
  int         s_run, m_value, m_err, ecount, last_rise, m_period;
  bit         have_ref, m_vv, m_ill, m_seq, m_pv, dp0, dp1, d_last, seen;

  always @(posedge clk) begin : model
    logic [6:0] ns;
    int         idx;
    bit         nd;
    cyc_n++;
    started = 1'b1;
    m_vv = 0; m_ill = 0; m_seq = 0; m_pv = 0;
    if (!rst_n) begin
      sp0 = 0; sp1 = 0; s_last = 0; s_run = 1;
      have_ref = 0; m_value = 0; m_err = 0;
      dp0 = 0; dp1 = 0; d_last = 0; seen = 0; ecount = 0; last_rise = 0; m_period = 0;
    end else if (ena) begin
      ecount++;
      ns = sp0; sp0 = sp1; sp1 = seg_in;
      if (ns == s_last) begin
        if (s_run < 1000) s_run++;
      end else s_run = 1;
      s_last = ns;
      if (s_run == S) begin
        idx = lookup(ns);
        if (idx < 0) begin
          m_ill = 1;
          if (m_err < 255) m_err++;
        end else begin
          if (have_ref && idx != (m_value + 1) % MOD) begin
            m_seq = 1;
            if (m_err < 255) m_err++;
          end
          m_value = idx; m_vv = 1; have_ref = 1;
        end
      end
      nd = dp0; dp0 = dp1; dp1 = div_clk_in;
      if (PER_EN && nd && !d_last) begin
        if (seen) begin
          m_period = (ecount - last_rise > 65535) ? 65535 : ecount - last_rise;
          m_pv = 1;
        end
        seen = 1; last_rise = ecount;
      end
      d_last = nd;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("value_out", int'(value_out), m_value);
      chk("value_valid", int'(value_valid), int'(m_vv));
      chk("illegal_pat", int'(illegal_pat), int'(m_ill));
      chk("seq_err", int'(seq_err), int'(m_seq));
      chk("err_count", int'(err_count), m_err);
      chk("period_out", int'(period_out), m_period);
      chk("period_valid", int'(period_valid), int'(m_pv));
      if (value_valid) begin n_vv++; last_vv_cyc = cyc_n; end
      if (seq_err) n_seq++;
      if (illegal_pat) n_ill++;
      if (period_valid) n_pv++;
    end
  end

  initial begin
    int b_vv, b_seq, b_ill, b_pv, t0, nib, dcnt, hold, r;
    rst_n = 0; ena = 1; seg_in = 7'h3F; div_clk_in = 0;
    cyc(3);
    chk("rst_value", int'(value_out), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_vv", int'(value_valid), 0);

    // First value after reset
    rst_n = 1; b_vv = n_vv; b_seq = n_seq;
    cyc(10);
    chk("first_vv_count", n_vv - b_vv, 1);
    chk("first_value", int'(value_out), 0);
    chk("first_seq", n_seq - b_seq, 0);
    chk("first_err", int'(err_count), 0);

    // Full incrementing sequence 1..9,0
    b_vv = n_vv; b_seq = n_seq; t0 = 0;
    for (int i = 1; i <= 10; i++) begin
      seg_in = tbl[i % 10];
      if (i == 1) t0 = cyc_n;
      cyc(8);
      if (i == 1) chk("latency", last_vv_cyc - t0, S + 2);
    end
    chk("seq_vv_count", n_vv - b_vv, 10);
    chk("seq_last_value", int'(value_out), 0);
    chk("seq_no_err", n_seq - b_seq, 0);

    // Short glitch: 06 never accepted; the restored 3F is a new run and re-taken
    b_vv = n_vv; b_seq = n_seq;
    seg_in = tbl[1]; cyc(2);
    seg_in = tbl[0]; cyc(10);
    chk("glitch_vv", n_vv - b_vv, 1);
    chk("glitch_value", int'(value_out), 0);
    chk("glitch_seq", n_seq - b_seq, 1);

    // Skip then illegal, from a fresh reset
    rst_n = 0; cyc(2); rst_n = 1;
    cyc(10);
    b_seq = n_seq;
    seg_in = 7'h5B; cyc(8);
    chk("skip_seq", n_seq - b_seq, 1);
    chk("skip_err", int'(err_count), 1);
    chk("skip_value", int'(value_out), 2);
    b_ill = n_ill;
    seg_in = 7'h55; cyc(8);
    chk("illegal_cnt", n_ill - b_ill, 1);
    chk("illegal_err", int'(err_count), 2);
    chk("illegal_value", int'(value_out), 2);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      seg_in = (i % 2 == 0) ? 7'h00 : 7'h3F;
      cyc(6);
    end
    chk("err_saturate", int'(err_count), 255);

    // Period measurement, then an ena pause mid-period
    rst_n = 0; seg_in = 7'h3F; cyc(2); rst_n = 1;
    b_pv = n_pv;
    for (int k = 0; k < 100; k++) begin
      div_clk_in = ((k % 20) < 10);
      cyc(1);
    end
    chk("period_pulses", n_pv - b_pv, PER_EN ? 4 : 0);
    chk("period_value", int'(period_out), PER_EN ? 20 : 0);
    b_pv = n_pv;
    for (int k = 100; k < 130; k++) begin
      if (k == 110) begin ena = 0; cyc(7); ena = 1; end
      div_clk_in = ((k % 20) < 10);
      cyc(1);
    end
    chk("pause_pulses", n_pv - b_pv, PER_EN ? 2 : 0);
    chk("pause_period", int'(period_out), PER_EN ? 20 : 0);

    // Randomized tail: mostly in-sequence digits, jumps, garbage, glitches, ena drops
    nib = 0; dcnt = 3;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        nib = (nib + 1) % MOD;
        seg_in = tbl[nib];
      end else if (r < 85) begin
        nib = $urandom_range(0, 15);
        seg_in = tbl[nib];
      end else begin
        seg_in = 7'($urandom_range(0, 127));
      end
      hold = $urandom_range(1, 9);
      for (int j = 0; j < hold; j++) begin
        ena = ($urandom_range(0, 7) != 0);
        if (dcnt == 0) begin
          div_clk_in = ~div_clk_in;
          dcnt = $urandom_range(1, 12);
        end else dcnt--;
        cyc(1);
      end
      if (i == 150) begin
        ena = 0; rst_n = 0; cyc(2); rst_n = 1; ena = 1;
      end
    end
    ena = 1;
    cyc(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
